// File: rtl/alu_exec_if.sv
// Request/response channel of the ALU execute unit.
// The requester drives operands and out_ready; the unit drives in_ready and the result.
interface alu_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      func7;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_op, func7, func3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, func7, func3, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32-style integer execute unit: single-cycle ALU ops plus optional iterative
// multiply/divide (one bit per cycle) behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned M_EXT = 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN);
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
    typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_ILL} kind_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op3_q, op3_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
    logic [XLEN-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic              out_valid_q, out_valid_d, zero_q, zero_d, illegal_q, illegal_d;
    logic [XLEN-1:0]   result_q, result_d;

    kind_e             kind_c;
    logic [XLEN-1:0]   alu_res_c, base_c, sub_c, sll_c, srl_c, sra_c, slt_c, sltu_c;
    logic [SHW-1:0]    shamt_c;
    logic              accept_c, sa_c, sb_c, a_neg_c, b_neg_c, done_c, ge_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c, addend_c, quo_c, rem_c, fin_c;
    logic [XLEN:0]     sum_c, rs_c;
    logic [2*XLEN-1:0] prod_c;

    assign bus.in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign accept_c      = bus.in_valid && bus.in_ready;

    // Single-cycle datapath and instruction decode
    always_comb begin
        shamt_c = bus.op_b[SHW-1:0];
        sub_c   = bus.op_a - bus.op_b;
        sll_c   = bus.op_a << shamt_c;
        srl_c   = bus.op_a >> shamt_c;
        sra_c   = $signed(bus.op_a) >>> shamt_c;
        slt_c   = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
        sltu_c  = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
        case (bus.func3)
            3'b000:  base_c = bus.op_a + bus.op_b;
            3'b001:  base_c = sll_c;
            3'b010:  base_c = slt_c;
            3'b011:  base_c = sltu_c;
            3'b100:  base_c = bus.op_a ^ bus.op_b;
            3'b101:  base_c = srl_c;
            3'b110:  base_c = bus.op_a | bus.op_b;
            default: base_c = bus.op_a & bus.op_b;
        endcase

        kind_c    = K_ILL;
        alu_res_c = '0;
        case (bus.alu_op)
            2'b00: begin kind_c = K_ALU; alu_res_c = bus.op_a + bus.op_b; end
            2'b01: begin kind_c = K_ALU; alu_res_c = sub_c; end
            2'b10: begin
                if (bus.func7 == F7_BASE) begin
                    kind_c = K_ALU; alu_res_c = base_c;
                end else if (bus.func7 == F7_ALT && bus.func3 == 3'b000) begin
                    kind_c = K_ALU; alu_res_c = sub_c;
                end else if (bus.func7 == F7_ALT && bus.func3 == 3'b101) begin
                    kind_c = K_ALU; alu_res_c = sra_c;
                end else if (bus.func7 == F7_MD && M_EXT != 0) begin
                    kind_c = bus.func3[2] ? K_DIV : K_MUL;
                end
            end
            default: begin
                if (bus.func3 == 3'b001) begin
                    if (bus.func7 == F7_BASE) begin kind_c = K_ALU; alu_res_c = sll_c; end
                end else if (bus.func3 == 3'b101) begin
                    if (bus.func7 == F7_BASE)     begin kind_c = K_ALU; alu_res_c = srl_c; end
                    else if (bus.func7 == F7_ALT) begin kind_c = K_ALU; alu_res_c = sra_c; end
                end else begin
                    kind_c = K_ALU; alu_res_c = base_c;
                end
            end
        endcase

        // Operand signedness for MUL/DIV: iterate on magnitudes, fix sign at the end
        sa_c    = (kind_c == K_MUL) ? (bus.func3 == 3'b001 || bus.func3 == 3'b010) : !bus.func3[0];
        sb_c    = (kind_c == K_MUL) ? (bus.func3 == 3'b001) : !bus.func3[0];
        a_neg_c = sa_c && bus.op_a[XLEN-1];
        b_neg_c = sb_c && bus.op_b[XLEN-1];
        abs_a_c = a_neg_c ? -bus.op_a : bus.op_a;
        abs_b_c = b_neg_c ? -bus.op_b : bus.op_b;
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op3_d       = op3_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        bz_d        = bz_q;
        a_d         = a_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        done_c      = 1'b0;
        addend_c    = '0;
        sum_c       = '0;
        rs_c        = '0;
        ge_c        = 1'b0;
        prod_c      = '0;
        quo_c       = '0;
        rem_c       = '0;
        fin_c       = '0;

        case (state_q)
            IDLE: begin
                if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
                if (accept_c) begin
                    op3_d  = bus.func3;
                    a_d    = bus.op_a;
                    bz_d   = (bus.op_b == '0);
                    neg_d  = a_neg_c ^ b_neg_c;
                    rneg_d = a_neg_c;
                    cnt_d  = '0;
                    case (kind_c)
                        K_MUL: begin state_d = MUL; hi_d = '0; lo_d = abs_b_c; mcand_d = abs_a_c; end
                        K_DIV: begin state_d = DIV; hi_d = '0; lo_d = abs_a_c; mcand_d = abs_b_c; end
                        default: begin
                            out_valid_d = 1'b1;
                            result_d    = alu_res_c;
                            zero_d      = (alu_res_c == '0);
                            illegal_d   = (kind_c == K_ILL);
                        end
                    endcase
                end
            end
            MUL: begin
                addend_c = lo_q[0] ? mcand_q : '0;
                sum_c    = {1'b0, hi_q} + {1'b0, addend_c};
                {hi_d, lo_d} = {sum_c, lo_q[XLEN-1:1]};
                done_c   = (cnt_q == CW'(XLEN-1));
                prod_c   = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
                fin_c    = (op3_q == 3'b000) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
            end
            DIV: begin
                rs_c  = {hi_q, lo_q[XLEN-1]};
                ge_c  = (rs_c >= {1'b0, mcand_q});
                hi_d  = ge_c ? XLEN'(rs_c - {1'b0, mcand_q}) : rs_c[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], ge_c};
                done_c = (cnt_q == CW'(XLEN-1));
                quo_c = bz_q ? '1  : (neg_q  ? -lo_d : lo_d);
                rem_c = bz_q ? a_q : (rneg_q ? -hi_d : hi_d);
                fin_c = op3_q[1] ? rem_c : quo_c;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (done_c) begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                result_d    = fin_c;
                zero_d      = (fin_c == '0);
                illegal_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op3_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            bz_q        <= 1'b0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op3_q       <= op3_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            bz_q        <= bz_d;
            a_q         <= a_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: ALU decode, MUL/DIV latency and corner cases,
// backpressure, reset behaviour, and the M_EXT=0 variant.
module tb_alu_exec_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_exec_if #(.XLEN(XLEN)) bus ();
    alu_exec_if #(.XLEN(XLEN)) bus0 ();

    alu_exec_unit #(.XLEN(XLEN), .M_EXT(1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    alu_exec_unit #(.XLEN(XLEN), .M_EXT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.func7    = f7;
        bus.func3    = f3;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    task automatic single(input string tag, input logic [1:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill);
        drive(op, f7, f3, a, b);
        check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check1({tag, "_out_valid"}, bus.out_valid, 1'b1);
        check({tag, "_result"}, bus.result, exp_res);
        check1({tag, "_zero"}, bus.zero, exp_res == 32'h0);
        check1({tag, "_illegal"}, bus.illegal, exp_ill);
    endtask

    // Samples from the cycle after accept until out_valid; counts cycles and stalled cycles
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        int low;
        n = 0;
        low = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (bus.in_ready === 1'b0) low++;
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(low), 32'(exp_lat));
    endtask

    task automatic muldiv(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        drive(2'b10, 7'b0000001, f3, a, b);
        check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        wait_done(tag, XLEN);
        check({tag, "_result"}, bus.result, exp_res);
        check1({tag, "_zero"}, bus.zero, exp_res == 32'h0);
        check1({tag, "_illegal"}, bus.illegal, 1'b0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.func7 = 7'h0; bus.func3 = 3'h0;
        bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.alu_op = 2'b00; bus0.func7 = 7'h0; bus0.func3 = 3'h0;
        bus0.op_a = '0; bus0.op_b = '0; bus0.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'h0);
        check1("rst_zero", bus.zero, 1'b0);
        check1("rst_illegal", bus.illegal, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check1("post_rst_in_ready", bus.in_ready, 1'b1);
        tick();

        // Single-cycle ALU ops
        single("and",    2'b10, 7'b0000000, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        single("sra",    2'b10, 7'b0100000, 3'b101, 32'h8000_0000, 32'd5,         32'hFC00_0000, 1'b0);
        single("iaddf7", 2'b11, 7'b0100000, 3'b000, 32'h8000_0000, 32'd5,         32'h8000_0005, 1'b0);
        single("sub",    2'b01, 7'b0000000, 3'b000, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
        single("slt",    2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
        single("sltu",   2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        single("slli",   2'b11, 7'b0000000, 3'b001, 32'd1,         32'h24,        32'h10,        1'b0);
        single("srai",   2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
        single("addwrap",2'b00, 7'b0000000, 3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        single("ill_r",  2'b10, 7'b0100000, 3'b001, 32'd3,         32'd4,         32'd0,         1'b1);
        single("ill_i",  2'b11, 7'b0100000, 3'b001, 32'd3,         32'd4,         32'd0,         1'b1);
        single("ill_f7", 2'b10, 7'b1111111, 3'b000, 32'd3,         32'd4,         32'd0,         1'b1);
        tick();

        // MUL with a request held pending while the multiplier runs
        drive(2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'd2);
        check1("mul_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(2'b00, 7'b0000000, 3'b000, 32'd3, 32'd4);
        wait_done("mul", XLEN);
        check("mul_result", bus.result, 32'hFFFF_FFFE);
        check1("mul_in_ready_done", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("stalled_add_result", bus.result, 32'd7);
        check1("stalled_add_valid", bus.out_valid, 1'b1);
        tick();

        muldiv("mulhu",   3'b011, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
        muldiv("mulh",    3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        muldiv("mulh_mm", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        muldiv("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        muldiv("div0",    3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF);
        muldiv("rem0",    3'b110, 32'd7,         32'd0,         32'd7);
        muldiv("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        muldiv("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        muldiv("remneg",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        muldiv("divneg",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        muldiv("divu",    3'b101, 32'd100,       32'd7,         32'd14);
        muldiv("remu",    3'b111, 32'd100,       32'd7,         32'd2);

        // Backpressure: result holds, new request stalled
        bus.out_ready = 1'b0;
        drive(2'b00, 7'b0000000, 3'b000, 32'h1234_0000, 32'h0000_5678);
        tick();
        drive(2'b00, 7'b0000000, 3'b000, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check1("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_result", bus.result, 32'h1234_5678);
            check1("bp_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check1("bp_release_in_ready", bus.in_ready, 1'b1);
        tick();
        check("bp_next_result", bus.result, 32'd2);

        // Back-to-back adds, one result per cycle
        for (int i = 1; i <= 4; i++) begin
            drive(2'b00, 7'b0000000, 3'b000, 32'(i), 32'(10 * i));
            check1("b2b_in_ready", bus.in_ready, 1'b1);
            tick();
            check1("b2b_out_valid", bus.out_valid, 1'b1);
            check("b2b_result", bus.result, 32'(11 * i));
        end
        bus.in_valid = 1'b0;
        tick();
        check1("b2b_drained", bus.out_valid, 1'b0);

        // Asynchronous reset clears a held result
        bus.out_ready = 1'b0;
        drive(2'b00, 7'b0000000, 3'b000, 32'd5, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        check1("hold_before_rst", bus.out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check1("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_result", bus.result, 32'h0);
        check1("async_rst_in_ready", bus.in_ready, 1'b0);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Reset mid-DIVU abandons the operation
        drive(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check1("divu_rst_out_valid", bus.out_valid, 1'b0);
        check1("divu_rst_in_ready", bus.in_ready, 1'b0);
        #1 rst = 1'b0;
        #1;
        check1("divu_rst_idle", bus.in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("divu_rst_no_result", 32'(seen), 32'd0);

        // M_EXT=0: multiply encoding is illegal
        bus0.in_valid = 1'b1; bus0.alu_op = 2'b10; bus0.func7 = 7'b0000001;
        bus0.func3 = 3'b000; bus0.op_a = 32'd3; bus0.op_b = 32'd4;
        check1("noext_in_ready", bus0.in_ready, 1'b1);
        tick();
        bus0.in_valid = 1'b0;
        check1("noext_out_valid", bus0.out_valid, 1'b1);
        check1("noext_illegal", bus0.illegal, 1'b1);
        check("noext_result", bus0.result, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be >= 8 and even.
REQ-002 Parameter M_EXT, default 1, enables RV-M multiply/divide; 0 decodes those encodings as illegal.
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 alu_op  input  2  ALUOp: 00 add, 01 sub (branch compare), 10 R-type, 11 I-type.
REQ-008 func7  input  7  instruction bits [31:25].
REQ-009 func3  input  3  instruction bits [14:12].
REQ-010 op_a, op_b  input  XLEN each  operands (op_b = immediate for I-type).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  XLEN  operation result.
REQ-014 zero  output  1  result == 0.
REQ-015 illegal  output  1  unsupported encoding.

Function
REQ-016 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready; inputs sampled only at in transfer.
REQ-017 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), allowing back-to-back single-cycle ops.
REQ-018 Decode: 00 ADD; 01 SUB; 10 with func7=0000000: func3 000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL,110 OR,111 AND; func7=0100000: 000 SUB,101 SRA; func7=0000001 (M_EXT=1): 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU.
REQ-019 I-type (11): func3 as R-type, func7 ignored except func3 001 needs func7=0000000 and 101 selects SRL (0000000) or SRA (0100000); func3 000 never SUB.
REQ-020 Any other combination SHALL produce illegal=1, result=0, single-cycle latency.
REQ-021 Shift amount = op_b[log2(XLEN)-1:0]; add/sub wrap modulo 2^XLEN; SLT signed, SLTU unsigned, result 0 or 1.
REQ-022 States: IDLE, MUL, DIV. Single-cycle op accepted in cycle N -> out_valid, result registered in cycle N+1, state stays IDLE.
REQ-023 MUL/DIV ops: IDLE->MUL or DIV on accept; iterative, one bit per cycle, XLEN iterations; out_valid rises in cycle N+XLEN+1; state returns to IDLE same edge out_valid rises.
REQ-024 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of signed x signed, signed x unsigned, unsigned x unsigned 2XLEN-bit product.
REQ-025 Divide by zero: DIV/DIVU quotient all ones; REM/REMU = op_a.
REQ-026 Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0.
REQ-027 DIV/REM round toward zero; remainder sign follows dividend.
REQ-028 out_valid, result, zero, illegal SHALL hold stable while out_valid && !out_ready.
REQ-029 in_valid during MUL/DIV SHALL be stalled (in_ready=0), not dropped.

Reset
REQ-030 rst asserted: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, iteration counter=0, immediately, regardless of clk.
REQ-031 rst mid MUL/DIV SHALL abandon the operation; no result issued after release.
REQ-032 in_ready=0 while rst is high; first accept possible on first clk edge after release.

Verification
REQ-033 alu_op=10, func7=0000000, func3=111, a=0xF0F0_F0F0, b=0x0FF0_0FF0 -> next cycle result=0x00F0_00F0, zero=0, illegal=0.
REQ-034 alu_op=10, func7=0100000, func3=101, a=0x8000_0000, b=5 -> result=0xFC00_0000; same with alu_op=11 func3=000 func7=0100000 -> ADD, result=0x8000_0005.
REQ-035 MUL a=0xFFFF_FFFF, b=2: in_ready low 32 cycles, out_valid at N+33, result=0xFFFF_FFFE; MULHU same operands -> 0x0000_0001.
REQ-036 DIV a=7, b=0 -> 0xFFFF_FFFF; REM a=7, b=0 -> 7; DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000; REM -7/2 -> 0xFFFF_FFFF.
REQ-037 out_ready=0 for 5 cycles after result: outputs unchanged, in_ready=0; back-to-back ADDs with out_ready=1 -> one result per cycle.
REQ-038 rst pulsed at iteration 10 of DIVU -> out_valid=0 instantly, no result after release; func7=0000001 with M_EXT=0 -> illegal=1, result=0.
